// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial a - b - bin with start/busy/done handshake
// Flags: borrow-out, signed overflow, zero.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last;
    logic [DIGIT-1:0] w_d;
    logic             w_borrow_msb;
    logic             w_borrow_out;
    logic [WIDTH-1:0] w_res_next;

    // Ripple-borrow digit cell; also exposes the borrow entering the digit's top bit.
    always_comb begin
        logic bw;
        w_d          = '0;
        w_borrow_msb = r_borrow;
        bw           = r_borrow;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                w_borrow_msb = bw;
            end
            w_d[i] = r_a[i] ^ r_b[i] ^ bw;
            bw     = (~r_a[i] & r_b[i]) | (~(r_a[i] ^ r_b[i]) & bw);
        end
        w_borrow_out = bw;
    end

    assign w_res_next = (r_res >> DIGIT) | (WIDTH'(w_d) << (WIDTH - DIGIT));
    assign w_accept   = start && (r_state != S_RUN);
    assign w_last     = (r_state == S_RUN) && (r_cnt == CW'(STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_res    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_a      <= r_a >> DIGIT;
            r_b      <= r_b >> DIGIT;
            r_borrow <= w_borrow_out;
            r_res    <= w_res_next;
            r_cnt    <= r_cnt + CW'(1);
            // Published results only move on the final step, so they hold through RUN.
            if (w_last) begin
                r_diff <= w_res_next;
                r_bout <= w_borrow_out;
                r_ovf  <= w_borrow_msb ^ w_borrow_out;
                r_zero <= (w_res_next == '0);
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;
    assign zero = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (8/1, 8/4, 16/2)
module tb_serial_subtractor;

    typedef struct {
        int          k;
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        z;
        longint      due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i [3];
    logic [15:0] a_i [3];
    logic [15:0] b_i [3];
    logic        bin_i [3];
    logic        busy_o [3];
    logic        done_o [3];
    logic        bout_o [3];
    logic        ovf_o [3];
    logic        zero_o [3];
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [15:0] d2;

    exp_t   sb[$];
    exp_t   held [3];
    longint cyc = 0;
    int     n_checks = 0;
    int     n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d0 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .a(a_i[0][7:0]), .b(b_i[0][7:0]),
        .bin(bin_i[0]), .busy(busy_o[0]), .done(done_o[0]), .diff(d0), .bout(bout_o[0]),
        .ovf(ovf_o[0]), .zero(zero_o[0]));
    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .a(a_i[1][7:0]), .b(b_i[1][7:0]),
        .bin(bin_i[1]), .busy(busy_o[1]), .done(done_o[1]), .diff(d1), .bout(bout_o[1]),
        .ovf(ovf_o[1]), .zero(zero_o[1]));
    serial_subtractor #(.WIDTH(16), .DIGIT(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start_i[2]), .a(a_i[2]), .b(b_i[2]),
        .bin(bin_i[2]), .busy(busy_o[2]), .done(done_o[2]), .diff(d2), .bout(bout_o[2]),
        .ovf(ovf_o[2]), .zero(zero_o[2]));

    function automatic int width_of(int k);
        return (k == 2) ? 16 : 8;
    endfunction

    function automatic int steps_of(int k);
        return (k == 0) ? 8 : ((k == 1) ? 2 : 8);
    endfunction

    function automatic logic [15:0] diff_of(int k);
        case (k)
            0:       return {8'h00, d0};
            1:       return {8'h00, d1};
            default: return d2;
        endcase
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic exp_t model(int k, logic [15:0] a, logic [15:0] b, logic bin);
        exp_t   e;
        int     w = width_of(k);
        longint m = (longint'(1) << w) - 1;
        longint ua = longint'(a) & m;
        longint ub = longint'(b) & m;
        longint half = longint'(1) << (w - 1);
        longint sa = (ua >= half) ? ua - (m + 1) : ua;
        longint sb_ = (ub >= half) ? ub - (m + 1) : ub;
        longint full = ua - ub - longint'(bin);
        longint sres = sa - sb_ - longint'(bin);
        e.k   = k;
        e.d   = 16'(full & m);
        e.bo  = (full < 0);
        e.ov  = (sres < -half) || (sres > half - 1);
        e.z   = ((full & m) == 0);
        e.due = 0;
        return e;
    endfunction

    task automatic chk(string name, int k, longint got, longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (cycle %0d)", name, k, got, want, cyc);
    endtask

    function automatic int find_exp(int k);
        foreach (sb[i]) if (sb[i].k == k) return i;
        return -1;
    endfunction

    function automatic int pending(int k);
        int n = 0;
        foreach (sb[i]) if (sb[i].k == k) n++;
        return n;
    endfunction

    // Monitor: pops expected results on each done, checks that results hold during RUN.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (done_o[k]) begin
                    int   idx;
                    exp_t e;
                    idx = find_exp(k);
                    if (idx < 0) begin
                        chk("unexpected_done", k, 1, 0);
                    end else begin
                        e = sb[idx];
                        sb.delete(idx);
                        chk("diff", k, diff_of(k), e.d);
                        chk("bout", k, bout_o[k], e.bo);
                        chk("ovf", k, ovf_o[k], e.ov);
                        chk("zero", k, zero_o[k], e.z);
                        chk("latency", k, cyc, e.due);
                        chk("busy_at_done", k, busy_o[k], 0);
                        held[k] = e;
                    end
                end else if (busy_o[k]) begin
                    chk("hold_diff", k, diff_of(k), held[k].d);
                    chk("hold_flags", k, {bout_o[k], ovf_o[k], zero_o[k]},
                        {held[k].bo, held[k].ov, held[k].z});
                end
            end
        end
    end

    // Drives start at a negedge; returns with start still high.
    task automatic drive(int k, logic [15:0] a, logic [15:0] b, logic bin);
        exp_t e;
        a_i[k]     = a;
        b_i[k]     = b;
        bin_i[k]   = bin;
        start_i[k] = 1'b1;
        e          = model(k, a, b, bin);
        e.due      = cyc + 1 + steps_of(k);
        sb.push_back(e);
    endtask

    task automatic wait_done(int k);
        int t = 0;
        while (pending(k) > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (pending(k) > 0) chk("timeout", k, 1, 0);
    endtask

    task automatic issue(int k, logic [15:0] a, logic [15:0] b, logic bin);
        @(negedge clk);
        drive(k, a, b, bin);
        @(negedge clk);
        start_i[k] = 1'b0;
        wait_done(k);
    endtask

    task automatic op_expect(int k, logic [15:0] a, logic [15:0] b, logic bin,
                             logic [15:0] ed, logic eb, logic eo, logic ez);
        issue(k, a, b, bin);
        chk("plan_diff", k, diff_of(k), ed);
        chk("plan_bout", k, bout_o[k], eb);
        chk("plan_ovf", k, ovf_o[k], eo);
        chk("plan_zero", k, zero_o[k], ez);
    endtask

    task automatic check_zero_outputs(string name, int k);
        chk(name, k, {busy_o[k], done_o[k], bout_o[k], ovf_o[k], zero_o[k]}, 0);
        chk(name, k, diff_of(k), 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            start_i[k] = 1'b0;
            a_i[k]     = '0;
            b_i[k]     = '0;
            bin_i[k]   = 1'b0;
            held[k]    = model(k, 16'h0, 16'h0, 1'b0);
            held[k].z  = 1'b0;
        end
        #1;
        for (int k = 0; k < 3; k++) check_zero_outputs("reset_state", k);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op_expect(0, 16'h05, 16'h03, 1'b0, 16'h02, 1'b0, 1'b0, 1'b0);
        op_expect(0, 16'h03, 16'h05, 1'b0, 16'hFE, 1'b1, 1'b0, 1'b0);
        op_expect(0, 16'h80, 16'h01, 1'b0, 16'h7F, 1'b0, 1'b1, 1'b0);
        op_expect(0, 16'h7F, 16'hFF, 1'b0, 16'h80, 1'b1, 1'b1, 1'b0);
        op_expect(0, 16'h5A, 16'h5A, 1'b0, 16'h00, 1'b0, 1'b0, 1'b1);
        op_expect(0, 16'h00, 16'h00, 1'b1, 16'hFF, 1'b1, 1'b0, 1'b0);
        op_expect(1, 16'hA3, 16'h4C, 1'b0, 16'h57, 1'b0, 1'b1, 1'b0);
        op_expect(2, 16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);

        // start held during RUN is ignored; start in DONE launches the next op.
        @(negedge clk);
        drive(0, 16'h9C, 16'h21, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_i[0]   = 16'($urandom);
            b_i[0]   = 16'($urandom);
            bin_i[0] = 1'($urandom);
        end
        @(negedge clk);
        chk("done_before_b2b", 0, done_o[0], 1);
        drive(0, 16'h44, 16'h45, 1'b1);
        @(negedge clk);
        start_i[0] = 1'b0;
        chk("b2b_busy", 0, busy_o[0], 1);
        wait_done(0);

        // Asynchronous reset three cycles into RUN aborts the operation.
        issue(0, 16'h33, 16'h11, 1'b0);
        @(negedge clk);
        drive(0, 16'hF0, 16'h0F, 1'b0);
        @(negedge clk);
        start_i[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_reset", 0);
        while (find_exp(0) >= 0) sb.delete(find_exp(0));
        for (int k = 0; k < 3; k++) begin
            held[k] = model(k, 16'h0, 16'h0, 1'b0);
            held[k].z = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_zero_outputs("after_reset", 0);
        op_expect(0, 16'h10, 16'h01, 1'b0, 16'h0F, 1'b0, 1'b0, 1'b0);

        fork
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                issue(0, 16'($urandom), 16'($urandom), 1'($urandom));
            end
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                issue(1, 16'($urandom), 16'($urandom), 1'($urandom));
            end
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                issue(2, 16'($urandom), 16'($urandom), 1'($urandom));
            end
        join

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 0, sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Parametrised, multi-cycle successor to the single-bit half subtractor. Computes diff = a - b - bin on WIDTH-bit operands.
- Processes DIGIT bits per clock through a ripple-borrow digit cell, with a registered borrow between digits.
- Single-request start/busy/done handshake, so datapath blocks can share one small subtract cell across wide operands.
- Also reports borrow-out, signed overflow and zero flags.

Parameters:
- WIDTH, 8, operand and result width in bits; WIDTH >= 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly.
- STEPS, WIDTH/DIGIT, derived localparam; not overridable; number of RUN cycles.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled on a rising edge when not busy.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- bin  input  1  borrow-in; captured on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle.
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow out of bit WIDTH-1 (unsigned a < b + bin).
- ovf  output  1  signed (two's-complement) overflow.
- zero  output  1  high when diff == 0.

Behaviour:
- Reset: with rst_n low, state = IDLE immediately (asynchronous). busy, done, diff, bout, ovf, zero, the step counter, the shift registers and the internal borrow all = 0.
- Reset mid-operation aborts the operation. No done is produced. Outputs read 0 after reset releases.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> capture a, b and bin into internal operand/borrow registers, clear the counter, go to RUN, busy=1.
  - start=0 -> remain in IDLE.
- RUN, each cycle:
  - Take the low DIGIT bits of the a and b shift registers together with the current borrow.
  - Compute {borrow_next, d} = a_digit - b_digit - borrow as a (DIGIT+1)-bit subtract.
  - Shift d into the result register from the top, so the first digit lands at diff[DIGIT-1:0] after STEPS shifts.
  - Shift both operand registers right by DIGIT. Register borrow_next. Increment the counter.
- On the STEPS-th RUN cycle:
  - Go to DONE. busy=0 and done=1 in the following cycle.
  - diff, bout (= final borrow), ovf and zero update in that same edge.
- Latency: start sampled at edge E -> busy high from E to E+STEPS -> done high for exactly one cycle, edges E+STEPS to E+STEPS+1.
- ovf = (borrow into bit WIDTH-1) XOR bout. The cell exposes the internal borrow at the MSB position of the last digit; when DIGIT=1 this is the registered borrow before the last step.
- DONE:
  - Lasts one cycle, then IDLE.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation, no idle bubble).
- Results hold: diff, bout, ovf and zero hold their values until the next operation's done edge. They do not change during RUN.
- start while busy (RUN) is ignored. Operand inputs may change freely after the accepting edge.
- Wrap-around: diff is modulo 2^WIDTH. a=0, b=0, bin=1 gives all ones with bout=1.

Test Plan:
1. WIDTH=8, DIGIT=1: a=0x05, b=0x03, bin=0, start pulse -> busy for 8 cycles, then done pulse; diff=0x02, bout=0, ovf=0, zero=0.
2. a=0x03, b=0x05 -> diff=0xFE, bout=1, ovf=0. Then a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
3. a=b=0x5A, bin=0 -> diff=0x00, zero=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, zero=0.
4. WIDTH=8, DIGIT=4: a=0xA3, b=0x4C -> done exactly 2 cycles after start; diff=0x57, bout=0, ovf=1. WIDTH=16, DIGIT=2: a=0x1234, b=0x0235 -> diff=0x0FFF after 8 cycles.
5. Assert start every cycle during RUN with different operands -> the first operation's result is unaffected and only one done appears. Assert start in the DONE cycle -> the new operation begins and busy rises the next cycle.
6. Pull rst_n low 3 cycles into RUN -> all outputs are 0 immediately with no clock edge, and no done appears. After release, a fresh start with a=0x10, b=0x01 -> diff=0x0F.
